// File: rtl/lc3b_l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache for the LC-3b pipeline.
// Serves 16-bit word/byte requests and moves 128-bit lines to physical memory.
module lc3b_l1_cache (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_wmask,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned TAG_W  = 9;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned SETS   = 8;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t state;

  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [LINE_W-1:0] data_arr [SETS];
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [6:0]        bit_off;
  logic [LINE_W-1:0] line;
  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] merged_word;
  logic [LINE_W-1:0] merged_line;
  logic              req;
  logic              hit;
  logic              write_hit_en;
  logic              unused_addr_bit;

  assign req_tag  = mem_address[15:7];
  assign idx      = mem_address[6:4];
  assign off      = mem_address[3:1];
  assign bit_off  = {off, 4'b0000};
  assign line     = data_arr[idx];
  assign cur_word = line[bit_off +: WORD_W];
  assign req      = mem_read | mem_write;
  assign hit      = valid[idx] && (tag_arr[idx] == req_tag);
  // A write with no enabled bytes still completes but must not dirty the line.
  assign write_hit_en    = (state == IDLE) && mem_write && hit && (|mem_wmask);
  assign unused_addr_bit = mem_address[0];

  // Byte-enable merge of the write data into the addressed word of the line.
  always_comb begin
    merged_word = cur_word;
    if (mem_wmask[0]) merged_word[7:0]  = mem_wdata[7:0];
    if (mem_wmask[1]) merged_word[15:8] = mem_wdata[15:8];
    merged_line = line;
    merged_line[bit_off +: WORD_W] = merged_word;
  end

  // Controller state and per-set valid/dirty bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            state <= (valid[idx] && dirty[idx]) ? WRITEBACK : FILL;
          end else if (write_hit_en) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty[idx] <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage; contents are meaningful only where valid is set.
  always_ff @(posedge clk) begin
    if ((state == FILL) && pmem_resp) begin
      data_arr[idx] <= pmem_rdata;
      tag_arr[idx]  <= req_tag;
    end else if (write_hit_en) begin
      data_arr[idx] <= merged_line;
    end
  end

  // Port decode from the registered state; hits answer in the request cycle.
  always_comb begin
    mem_rdata    = cur_word;
    mem_resp     = 1'b0;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    case (state)
      IDLE: mem_resp = req && hit;
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[idx], idx, 4'b0000};
        pmem_wdata   = line;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], 4'b0000};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3b_l1_cache.sv
// Directed self-checking bench for lc3b_l1_cache: fills, hits, byte writes,
// dirty eviction, reset during a fill and combined read/write requests.
module tb_lc3b_l1_cache;

  logic         clk;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_wmask;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks;
  int failures;

  logic [127:0] line_a;
  logic [127:0] line_b;
  logic [127:0] exp_line;

  lc3b_l1_cache dut (
    .clk          (clk),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wmask    (mem_wmask),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_wmask = 2'b00;
    mem_wdata = 16'h0; mem_address = 16'h0; pmem_rdata = '0; pmem_resp = 1'b0;
    @(negedge clk);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL reset_resp got=%0h exp=0", mem_resp); end
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL reset_pmem_read got=%0h exp=0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_write got=%0h exp=0", pmem_write); end
    checks++; if (pmem_address !== 16'h0) begin failures++; $display("FAIL reset_pmem_addr got=%h exp=0000", pmem_address); end
    next_cycle();
  endtask

  task automatic test_cold_read();
    mem_read = 1'b1; mem_address = 16'h1234;
    #1;
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL cold_miss_resp got=%0h exp=0", mem_resp); end
    next_cycle();
    #1;
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL cold_fill_read got=%0h exp=1", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL cold_fill_write got=%0h exp=0", pmem_write); end
    checks++; if (pmem_address !== 16'h1230) begin failures++; $display("FAIL cold_fill_addr got=%h exp=1230", pmem_address); end
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL cold_fill_resp got=%0h exp=0", mem_resp); end
    pmem_rdata = line_a; pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL cold_after_read got=%0h exp=0", pmem_read); end
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL cold_resp got=%0h exp=1", mem_resp); end
    checks++; if (mem_rdata !== 16'hBEEF) begin failures++; $display("FAIL cold_rdata got=%h exp=beef", mem_rdata); end
    next_cycle();
    mem_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_read = 1'b1; mem_address = 16'h1230;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL hit0_resp got=%0h exp=1", mem_resp); end
    checks++; if (mem_rdata !== 16'h1000) begin failures++; $display("FAIL hit0_rdata got=%h exp=1000", mem_rdata); end
    next_cycle();
    mem_address = 16'h123E;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL hit7_resp got=%0h exp=1", mem_resp); end
    checks++; if (mem_rdata !== 16'h7777) begin failures++; $display("FAIL hit7_rdata got=%h exp=7777", mem_rdata); end
    checks++; if ((pmem_read | pmem_write) !== 1'b0) begin failures++; $display("FAIL hit_pmem_idle got=%0h exp=0", pmem_read | pmem_write); end
    next_cycle();
    mem_read = 1'b0;
  endtask

  task automatic test_byte_write();
    mem_write = 1'b1; mem_address = 16'h1234; mem_wmask = 2'b01; mem_wdata = 16'h00AA;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL bw_resp got=%0h exp=1", mem_resp); end
    next_cycle();
    mem_write = 1'b0; mem_read = 1'b1;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL bw_read_resp got=%0h exp=1", mem_resp); end
    checks++; if (mem_rdata !== 16'hBEAA) begin failures++; $display("FAIL bw_read_rdata got=%h exp=beaa", mem_rdata); end
    next_cycle();
    mem_read = 1'b0;
  endtask

  task automatic test_dirty_eviction();
    exp_line = line_a;
    exp_line[47:32] = 16'hBEAA;
    mem_read = 1'b1; mem_address = 16'h1A34;
    #1;
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL ev_miss_resp got=%0h exp=0", mem_resp); end
    next_cycle();
    #1;
    checks++; if (pmem_write !== 1'b1) begin failures++; $display("FAIL ev_wb_write got=%0h exp=1", pmem_write); end
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL ev_wb_read got=%0h exp=0", pmem_read); end
    checks++; if (pmem_address !== 16'h1230) begin failures++; $display("FAIL ev_wb_addr got=%h exp=1230", pmem_address); end
    checks++; if (pmem_wdata !== exp_line) begin failures++; $display("FAIL ev_wb_data got=%h exp=%h", pmem_wdata, exp_line); end
    next_cycle();
    #1;
    checks++; if (pmem_write !== 1'b1) begin failures++; $display("FAIL ev_wb_hold got=%0h exp=1", pmem_write); end
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL ev_wb_resp got=%0h exp=0", mem_resp); end
    pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    #1;
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL ev_fill_write got=%0h exp=0", pmem_write); end
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL ev_fill_read got=%0h exp=1", pmem_read); end
    checks++; if (pmem_address !== 16'h1A30) begin failures++; $display("FAIL ev_fill_addr got=%h exp=1a30", pmem_address); end
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL ev_fill_resp got=%0h exp=0", mem_resp); end
    pmem_rdata = line_b; pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL ev_resp got=%0h exp=1", mem_resp); end
    checks++; if (mem_rdata !== 16'hCAFE) begin failures++; $display("FAIL ev_rdata got=%h exp=cafe", mem_rdata); end
    next_cycle();
    mem_read = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    mem_read = 1'b1; mem_address = 16'h1234;
    next_cycle();
    #1;
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL rst_fill_read got=%0h exp=1", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL rst_clean_victim got=%0h exp=0", pmem_write); end
    reset = 1'b1; mem_read = 1'b0;
    next_cycle();
    reset = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL rst_pmem_read got=%0h exp=0", pmem_read); end
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL rst_resp got=%0h exp=0", mem_resp); end
    // 0x1A34 was resident before reset, so a miss here shows valid was cleared.
    mem_read = 1'b1; mem_address = 16'h1A34;
    #1;
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL rst_valid_cleared got=%0h exp=0", mem_resp); end
    next_cycle();
    #1;
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL rst_refill_read got=%0h exp=1", pmem_read); end
    checks++; if (pmem_address !== 16'h1A30) begin failures++; $display("FAIL rst_refill_addr got=%h exp=1a30", pmem_address); end
    pmem_rdata = line_b; pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    #1;
    checks++; if (mem_rdata !== 16'hCAFE || mem_resp !== 1'b1) begin failures++; $display("FAIL rst_refill_data got=%h/%0h exp=cafe/1", mem_rdata, mem_resp); end
    next_cycle();
    mem_read = 1'b0;
  endtask

  task automatic test_zero_mask();
    mem_write = 1'b1; mem_address = 16'h1A34; mem_wmask = 2'b00; mem_wdata = 16'hFFFF;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL zm_resp got=%0h exp=1", mem_resp); end
    next_cycle();
    mem_write = 1'b0; mem_read = 1'b1;
    #1;
    checks++; if (mem_rdata !== 16'hCAFE) begin failures++; $display("FAIL zm_data got=%h exp=cafe", mem_rdata); end
    next_cycle();
    // Line must still be clean: the miss goes straight to FILL.
    mem_address = 16'h1234;
    next_cycle();
    #1;
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL zm_not_dirty got=%0h exp=0", pmem_write); end
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL zm_fill got=%0h exp=1", pmem_read); end
    pmem_rdata = line_a; pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    #1;
    checks++; if (mem_rdata !== 16'hBEEF || mem_resp !== 1'b1) begin failures++; $display("FAIL zm_refill got=%h/%0h exp=beef/1", mem_rdata, mem_resp); end
    next_cycle();
    mem_read = 1'b0;
  endtask

  task automatic test_read_write_together();
    exp_line = line_a;
    exp_line[63:48] = 16'h5A33;
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 16'h1236;
    mem_wmask = 2'b10; mem_wdata = 16'h5A00;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL rw_resp got=%0h exp=1", mem_resp); end
    next_cycle();
    mem_write = 1'b0;
    #1;
    checks++; if (mem_rdata !== 16'h5A33) begin failures++; $display("FAIL rw_merge got=%h exp=5a33", mem_rdata); end
    next_cycle();
    mem_address = 16'h1A34;
    next_cycle();
    #1;
    checks++; if (pmem_write !== 1'b1) begin failures++; $display("FAIL rw_dirty got=%0h exp=1", pmem_write); end
    checks++; if (pmem_wdata !== exp_line) begin failures++; $display("FAIL rw_wb_data got=%h exp=%h", pmem_wdata, exp_line); end
    pmem_resp = 1'b1;
    next_cycle();
    pmem_rdata = line_b;
    #1;
    checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin failures++; $display("FAIL rw_fill got=%0h/%0h exp=1/0", pmem_read, pmem_write); end
    next_cycle();
    pmem_resp = 1'b0;
    #1;
    checks++; if (mem_rdata !== 16'hCAFE || mem_resp !== 1'b1) begin failures++; $display("FAIL rw_final got=%h/%0h exp=cafe/1", mem_rdata, mem_resp); end
    next_cycle();
    mem_read = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    line_a = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'hBEEF, 16'h1111, 16'h1000};
    line_b = {16'hA777, 16'hA666, 16'hA555, 16'hA444, 16'hA333, 16'hCAFE, 16'hA111, 16'hA000};
    test_reset();
    test_cold_read();
    test_back_to_back();
    test_byte_write();
    test_dirty_eviction();
    test_reset_mid_fill();
    test_zero_mask();
    test_read_write_together();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
